mem_access_sequencer: RTL and testbench

//  Sits between the execution engine and main memory. Buffers load/store requests in a

---
 rtl/mem_access_sequencer_if.sv | 32 +++
 rtl/mem_access_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request/response handshake and main-memory bus bundle for mem_access_sequencer.
// master: execution engine plus memory; slave: the sequencer.
interface mem_access_sequencer_if;
    logic         ReqValid;
    logic         ReqReady;
    logic         ReqWrite;
    logic [11:0]  ReqAddr;
    logic [255:0] ReqWData;
    logic         RspValid;
    logic         RspReady;
    logic         RspWrite;
    logic         RspErr;
    logic [255:0] RspData;
    logic [15:0]  address;
    logic         nRead;
    logic         nWrite;
    logic [255:0] ExeDataOut;
    logic [255:0] MemDataOut;
    logic         Busy;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, MemDataOut,
        input  ReqReady, RspValid, RspWrite, RspErr, RspData,
        input  address, nRead, nWrite, ExeDataOut, Busy
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, MemDataOut,
        output ReqReady, RspValid, RspWrite, RspErr, RspData,
        output address, nRead, nWrite, ExeDataOut, Busy
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Buffers load/store requests in a small FIFO and sequences them onto the
// main-memory bus, returning exactly one response per accepted request.
module mem_access_sequencer #(
    parameter int         FIFO_DEPTH = 2,
    parameter int         MEM_DEPTH  = 9,
    parameter logic [3:0] TARGET     = 4'h0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mem_access_sequencer_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + 12 + 256;
    localparam logic [11:0] MAX_WORD = 12'(MEM_DEPTH);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RD_ISSUE   = 3'd1;
    localparam logic [2:0] RD_CAPTURE = 3'd2;
    localparam logic [2:0] WR_ISSUE   = 3'd3;
    localparam logic [2:0] RSP_HOLD   = 3'd4;

    logic [EW-1:0]  fifo_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [2:0]     state_q, state_d;
    logic [15:0]    address_q, address_d;
    logic [255:0]   exe_data_q, exe_data_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_write_q, rsp_write_d;
    logic           rsp_err_q, rsp_err_d;
    logic [255:0]   rsp_data_q, rsp_data_d;

    logic           full, empty, ready, push, pop;
    logic           head_write, head_err;
    logic [11:0]    head_addr;
    logic [255:0]   head_data;

    assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign ready = !Reset && !full;
    assign push  = bus.ReqValid && ready;

    assign {head_write, head_addr, head_data} = fifo_q[rd_ptr_q];
    assign head_err = (head_addr >= MAX_WORD);

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        exe_data_d  = exe_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: pop = !empty;
            RD_ISSUE: state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                state_d     = RSP_HOLD;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_data_d  = bus.MemDataOut;
            end
            WR_ISSUE: begin
                state_d     = RSP_HOLD;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end
            RSP_HOLD: begin
                if (bus.RspReady) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    // Popping on the handshake keeps the 3/2-cycle issue rate.
                    pop         = !empty;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            if (head_err) begin
                state_d     = RSP_HOLD;
                rsp_valid_d = 1'b1;
                rsp_write_d = head_write;
                rsp_err_d   = 1'b1;
                rsp_data_d  = '0;
            end else begin
                state_d   = head_write ? WR_ISSUE : RD_ISSUE;
                address_d = {TARGET, head_addr};
                if (head_write) begin
                    exe_data_d = head_data;
                end
            end
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {bus.ReqWrite, bus.ReqAddr, bus.ReqWData};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            address_q   <= '0;
            exe_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            address_q   <= address_d;
            exe_data_q  <= exe_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.ReqReady   = ready;
    assign bus.RspValid   = rsp_valid_q;
    assign bus.RspWrite   = rsp_write_q;
    assign bus.RspErr     = rsp_err_q;
    assign bus.RspData    = rsp_data_q;
    assign bus.address    = address_q;
    assign bus.ExeDataOut = exe_data_q;
    assign bus.nRead      = (state_q != RD_ISSUE);
    assign bus.nWrite     = (state_q != WR_ISSUE);
    assign bus.Busy       = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios plus a random run
// scored against an in-order request/memory model.
module tb_mem_access_sequencer;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mem_access_sequencer_if bus ();

    mem_access_sequencer #(
        .FIFO_DEPTH(2),
        .MEM_DEPTH (9),
        .TARGET    (4'h0)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    function automatic logic [255:0] init_word(int i);
        return {8{32'hC0DE_0000 | 32'(i)}};
    endfunction

    // Bus-side memory: preloads while Reset is high, registered read.
    logic [255:0] mem [16];
    logic [255:0] mem_rd_q;
    assign bus.MemDataOut = mem_rd_q;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            if (!bus.nWrite) mem[bus.address[3:0]] <= bus.ExeDataOut;
            if (!bus.nRead) mem_rd_q <= mem[bus.address[3:0]];
        end
    end

    typedef struct {
        logic         w;
        logic [11:0]  a;
        logic [255:0] d;
    } req_t;

    req_t         q[$];
    logic [255:0] ref_mem [16];
    int           total = 0;
    int           bad = 0;
    int           rd_lows = 0;
    int           wr_lows = 0;

    task automatic ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with inputs settled: scores what the
    // coming posedge will do, then advances to the next negedge.
    task automatic step();
        req_t         r;
        logic         e_err;
        logic [255:0] e_data;
        if (bus.ReqValid && bus.ReqReady)
            q.push_back('{bus.ReqWrite, bus.ReqAddr, bus.ReqWData});
        if (bus.RspValid && bus.RspReady) begin
            if (q.size() == 0) begin
                chk("spurious_rsp", 1, 0);
            end else begin
                r = q.pop_front();
                e_err = (r.a >= 12'd9);
                e_data = '0;
                if (!e_err && !r.w) e_data = ref_mem[r.a[3:0]];
                if (!e_err && r.w) ref_mem[r.a[3:0]] = r.d;
                chk("rsp_err", bus.RspErr, e_err);
                chk("rsp_write", bus.RspWrite, r.w);
                chk("rsp_data", bus.RspData, e_data);
            end
        end
        chk("strobe_excl", bus.nRead | bus.nWrite, 1);
        if (!bus.nRead) rd_lows++;
        if (!bus.nWrite) wr_lows++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic accept_loop();
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = bus.ReqReady;
            step();
        end
        chk("accept_timeout", acc, 1);
        bus.ReqValid = 1'b0;
    endtask

    task automatic send(input logic w, input logic [11:0] a,
                        input logic [255:0] d);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = w;
        bus.ReqAddr  = a;
        bus.ReqWData = d;
        accept_loop();
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && !bus.RspValid; i++) step();
        chk(tag, bus.RspValid, 1);
    endtask

    task automatic drain();
        bus.RspReady = 1'b1;
        for (int i = 0; i < 80 && q.size() > 0; i++) step();
        chk("drain_left", q.size(), 0);
        step();
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] hold_data;
        Reset = 1'b1;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr = '0;
        bus.ReqWData = '0;
        bus.RspReady = 1'b0;
        ref_init();
        repeat (3) @(negedge Clk);

        chk("rst_ready", bus.ReqReady, 0);
        chk("rst_rspvalid", bus.RspValid, 0);
        chk("rst_rspwrite", bus.RspWrite, 0);
        chk("rst_rsperr", bus.RspErr, 0);
        chk("rst_rspdata", bus.RspData, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_exedata", bus.ExeDataOut, 0);
        chk("rst_nread", bus.nRead, 1);
        chk("rst_nwrite", bus.nWrite, 1);
        chk("rst_busy", bus.Busy, 0);
        Reset = 1'b0;
        #1;
        chk("rel_ready", bus.ReqReady, 1);
        @(negedge Clk);
        bus.RspReady = 1'b1;

        // Load word 0: latency and single read strobe.
        rd_lows = 0;
        send(1'b0, 12'd0, '0);
        chk("ld_e0_valid", bus.RspValid, 0);
        step();
        chk("ld_e1_nread", bus.nRead, 0);
        chk("ld_e1_addr", bus.address, 16'h0000);
        step();
        chk("ld_e2_valid", bus.RspValid, 0);
        chk("ld_e2_nread", bus.nRead, 1);
        step();
        chk("ld_e3_valid", bus.RspValid, 1);
        chk("ld_e3_data", bus.RspData, init_word(0));
        drain();
        chk("ld_nread_cycles", rd_lows, 1);

        // Store then load of word 2.
        wr_lows = 0;
        send(1'b1, 12'd2, 256'hA5);
        send(1'b0, 12'd2, '0);
        chk("st_nwrite", bus.nWrite, 0);
        chk("st_addr", bus.address, 16'h0002);
        chk("st_exedata", bus.ExeDataOut, 256'hA5);
        step();
        chk("st_ack_valid", bus.RspValid, 1);
        chk("st_ack_write", bus.RspWrite, 1);
        chk("st_ack_data", bus.RspData, 0);
        step();
        wait_rsp("raw_wait");
        chk("raw_data", bus.RspData, 256'hA5);
        chk("raw_write", bus.RspWrite, 0);
        chk("raw_err", bus.RspErr, 0);
        drain();
        chk("st_nwrite_cycles", wr_lows, 1);

        // Out-of-range requests.
        rd_lows = 0;
        wr_lows = 0;
        send(1'b0, 12'd9, '0);
        step();
        chk("err_valid", bus.RspValid, 1);
        chk("err_flag", bus.RspErr, 1);
        chk("err_data", bus.RspData, 0);
        chk("err_nread", bus.nRead, 1);
        chk("err_nwrite", bus.nWrite, 1);
        drain();
        send(1'b1, 12'hFFF, rand_word());
        wait_rsp("err_st_wait");
        chk("err_st_write", bus.RspWrite, 1);
        chk("err_st_flag", bus.RspErr, 1);
        drain();
        chk("err_no_strobes", rd_lows + wr_lows, 0);

        // Back-pressure fills FIFO: 2 queued plus 1 in FSM.
        bus.RspReady = 1'b0;
        send(1'b0, 12'd1, '0);
        send(1'b0, 12'd3, '0);
        send(1'b0, 12'd5, '0);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr = 12'd7;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_low", bus.ReqReady, 0);
            step();
        end
        chk("bp_hold_valid", bus.RspValid, 1);
        chk("bp_queued", q.size(), 3);
        bus.RspReady = 1'b1;
        accept_loop();
        drain();

        // Stalled response stays stable, no strobes.
        bus.RspReady = 1'b0;
        send(1'b0, 12'd1, '0);
        wait_rsp("stall_wait");
        hold_data = ref_mem[1];
        rd_lows = 0;
        wr_lows = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.RspValid, 1);
            chk("stall_data", bus.RspData, hold_data);
            step();
        end
        chk("stall_strobes", rd_lows + wr_lows, 0);
        drain();

        // Reset during RD_ISSUE with a store still queued.
        bus.RspReady = 1'b1;
        send(1'b0, 12'd6, '0);
        send(1'b1, 12'd7, rand_word());
        chk("mid_nread_low", bus.nRead, 0);
        Reset = 1'b1;
        #1;
        chk("mid_nread", bus.nRead, 1);
        chk("mid_rspvalid", bus.RspValid, 0);
        chk("mid_busy", bus.Busy, 0);
        chk("mid_ready", bus.ReqReady, 0);
        q.delete();
        ref_init();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("mid_rel_ready", bus.ReqReady, 1);
        for (int i = 0; i < 4; i++) step();
        chk("mid_no_rsp", bus.RspValid, 0);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 300; n++) begin
            bus.ReqValid = 1'($urandom_range(0, 1));
            bus.ReqWrite = 1'($urandom_range(0, 1));
            bus.ReqAddr = ($urandom_range(0, 7) == 0) ? 12'hFFF
                        : 12'($urandom_range(0, 10));
            bus.ReqWData = rand_word();
            bus.RspReady = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.ReqValid = 1'b0;
        drain();
        chk("end_busy", bus.Busy, 0);
        for (int i = 0; i < 9; i++) chk("end_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
